// File: rtl/i2s_rx.sv
// I2S (Philips format) slave receiver: oversamples SCK/WS/SD in i_clk and emits L/R pairs on a valid/ready port.
// Optional I2S_RX_SYNC_EN macro adds 2-flop input synchronizers for a bus asynchronous to i_clk.
module i2s_rx #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i2s_sck,
  input  logic              i2s_ws,
  input  logic              i2s_sd,
  output logic [DATA_W-1:0] o_left,
  output logic [DATA_W-1:0] o_right,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overflow,
  input  logic              i_ovf_clr
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SYNC, RECV} state_t;

  logic sck_s, ws_s, sd_s, sck_d, sck_rise;

`ifdef I2S_RX_SYNC_EN
  logic [1:0] sck_sync, ws_sync, sd_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
    end else begin
      sck_sync <= {sck_sync[0], i2s_sck};
      ws_sync  <= {ws_sync[0],  i2s_ws};
      sd_sync  <= {sd_sync[0],  i2s_sd};
    end
  end

  assign sck_s = sck_sync[1];
  assign ws_s  = ws_sync[1];
  assign sd_s  = sd_sync[1];
`else
  assign sck_s = i2s_sck;
  assign ws_s  = i2s_ws;
  assign sd_s  = i2s_sd;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) sck_d <= 1'b0;
    else          sck_d <= sck_s;
  end

  assign sck_rise = sck_s & ~sck_d;

  state_t            state;
  logic              ws_prev;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] left_hold;
  logic              left_ok;
  logic              ws_edge;
  logic [IDX_W-1:0]  pos;
  logic [DATA_W-1:0] word_nxt;

  assign ws_edge = ws_s ^ ws_prev;
  assign pos     = IDX_W'(DATA_W - 1) - cnt[IDX_W-1:0];

  // Current bit merged in; at a word end this is the finished word (LSB included).
  always_comb begin
    word_nxt = shreg;
    if (cnt < CNT_W'(DATA_W)) word_nxt[pos] = sd_s;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      ws_prev    <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      left_hold  <= '0;
      left_ok    <= 1'b0;
      o_left     <= '0;
      o_right    <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (o_valid && i_ready) o_valid    <= 1'b0;
      if (i_ovf_clr)          o_overflow <= 1'b0;
      if (sck_rise)           ws_prev    <= ws_s;

      case (state)
        IDLE: begin
          cnt     <= '0;
          shreg   <= '0;
          left_ok <= 1'b0;
          if (i_enable) state <= SYNC;
        end
        default: begin
          if (!i_enable) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            left_ok <= 1'b0;
          end else if (sck_rise) begin
            if (ws_edge) begin
              cnt   <= '0;
              shreg <= '0;
              if (state == SYNC) begin
                // Lock on the start of a left word; the word ending here is discarded.
                if (ws_prev && !ws_s) state <= RECV;
              end else if (!ws_prev) begin
                left_hold <= word_nxt;
                left_ok   <= 1'b1;
              end else if (left_ok) begin
                left_ok <= 1'b0;
                if (!o_valid || i_ready) begin
                  o_left  <= left_hold;
                  o_right <= word_nxt;
                  o_valid <= 1'b1;
                end else begin
                  o_overflow <= 1'b1;
                end
              end
            end else begin
              shreg <= word_nxt;
              if (cnt < CNT_W'(DATA_W)) cnt <= cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives randomized Philips I2S frames and checks pairs against word-level expectations.
module tb_i2s_rx;
  localparam int DATA_W = 32;
`ifdef I2S_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ready = 1'b0, ovf_clr = 1'b0;
  logic sck = 1'b0, ws = 1'b0, sd = 1'b0;
  logic [DATA_W-1:0] o_left, o_right;
  logic o_valid, o_overflow;

  always #5 clk = ~clk;

  i2s_rx #(.DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd),
    .o_left(o_left), .o_right(o_right), .o_valid(o_valid),
    .i_ready(ready), .o_overflow(o_overflow), .i_ovf_clr(ovf_clr)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard of accepted pairs {left,right} and latency of the latest o_valid rise.
  logic [63:0] got[$];
  int last_rise_cyc = 0, last_lat = -1;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (o_valid === 1'b1 && ready === 1'b1) got.push_back({o_left, o_right});
    if (o_valid === 1'b1 && prev_v !== 1'b1) last_lat = cyc - last_rise_cyc;
    prev_v = o_valid;
  end

  // Bus stream: one entry per SCK period, channel and data bit of that slot.
  logic chq[$];
  logic sdq[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_word(input logic ch, input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      chq.push_back(ch);
      sdq.push_back(val[i]);
    end
  endtask

  task automatic add_frame(input logic [63:0] l, input logic [63:0] r, input int n);
    add_word(1'b0, l, n);
    add_word(1'b1, r, n);
  endtask

  // WS leads data by one SCK: a slot shows the channel of the following bit.
  task automatic play(input int lo, input int hi, input int h);
    for (int i = lo; i < hi; i++) begin
      sck = 1'b0;
      ws  = (i + 1 < chq.size()) ? chq[i+1] : ~chq[i];
      sd  = sdq[i];
      tick(h);
      sck = 1'b1;
      last_rise_cyc = cyc;
      tick(h);
    end
  endtask

  task automatic play_all(input int h);
    play(0, chq.size(), h);
    chq.delete();
    sdq.delete();
  endtask

  function automatic logic [63:0] rnd(input int n);
    logic [63:0] v;
    v = {$urandom, $urandom};
    if (n < 64) v = v & ((64'd1 << n) - 64'd1);
    return v;
  endfunction

  // Received value: first DATA_W bits MSB-aligned, zero-padded when short.
  function automatic logic [31:0] expw(input logic [63:0] v, input int n);
    logic [63:0] t;
    if (n >= 32) t = v >> (n - 32);
    else         t = v << (32 - n);
    return t[31:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sck = 1'($urandom); ws = 1'($urandom); sd = 1'($urandom);
      tick(1);
    end
    checks++; if (o_left !== '0)     begin failures++; $display("FAIL reset_left got=%h exp=0", o_left); end
    checks++; if (o_right !== '0)    begin failures++; $display("FAIL reset_right got=%h exp=0", o_right); end
    checks++; if (o_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", o_overflow); end
    sck = 1'b0; ws = 1'b0; sd = 1'b0;
    rst_n = 1'b1;
    tick(2);
    got.delete();
    add_frame(rnd(32), rnd(32), 32);
    play_all(2);
    tick(6);
    checks++; if (got.size() != 0 || o_valid !== 1'b0)
      begin failures++; $display("FAIL reset_disabled_out got=%0d pairs valid=%b exp=0", got.size(), o_valid); end
  endtask

  task automatic test_full_frame();
    enable = 1'b1; ready = 1'b1;
    tick(3);
    got.delete(); last_lat = -1;
    add_frame(rnd(32), rnd(32), 32);
    add_frame(64'hA5A5_0001, 64'h5A5A_8000, 32);
    play_all(3);
    tick(8);
    checks++; if (got.size() != 1) begin failures++; $display("FAIL full_count got=%0d exp=1", got.size()); end
    else begin
      checks++; if (got[0] !== {32'hA5A5_0001, 32'h5A5A_8000})
        begin failures++; $display("FAIL full_pair got=%h exp=%h", got[0], {32'hA5A5_0001, 32'h5A5A_8000}); end
    end
    checks++; if (last_lat != LAT) begin failures++; $display("FAIL full_latency got=%0d exp=%0d", last_lat, LAT); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q[$];
    logic [63:0] l, r;
    ready = 1'b1;
    got.delete();
    for (int f = 0; f < 4; f++) begin
      l = rnd(32); r = rnd(32);
      exp_q.push_back({expw(l, 32), expw(r, 32)});
      add_frame(l, r, 32);
      play_all(int'($urandom_range(2, 4)));
    end
    tick(8);
    checks++; if (got.size() != exp_q.size())
      begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_pair%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", o_overflow); end
  endtask

  task automatic test_mid_frame_enable();
    logic [63:0] l[3], r[3];
    enable = 1'b0; ready = 1'b1;
    tick(3);
    got.delete();
    for (int f = 0; f < 3; f++) begin
      l[f] = rnd(32); r[f] = rnd(32);
      add_frame(l[f], r[f], 32);
    end
    play(0, 48, 2);
    enable = 1'b1;
    play(48, chq.size(), 2);
    chq.delete(); sdq.delete();
    tick(8);
    checks++; if (got.size() != 2) begin failures++; $display("FAIL midena_count got=%0d exp=2", got.size()); end
    else for (int i = 0; i < 2; i++) begin
      checks++; if (got[i] !== {expw(l[i+1], 32), expw(r[i+1], 32)})
        begin failures++; $display("FAIL midena_pair%0d got=%h exp=%h", i, got[i], {expw(l[i+1], 32), expw(r[i+1], 32)}); end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] l1, r1, l2, r2;
    ready = 1'b0;
    got.delete();
    l1 = rnd(32); r1 = rnd(32); l2 = rnd(32); r2 = rnd(32);
    add_frame(l1, r1, 32);
    play_all(2);
    tick(6);
    checks++; if (o_valid !== 1'b1 || o_overflow !== 1'b0)
      begin failures++; $display("FAIL ovf_p1 got valid=%b ovf=%b exp valid=1 ovf=0", o_valid, o_overflow); end
    add_frame(l2, r2, 32);
    play_all(2);
    tick(6);
    checks++; if ({o_left, o_right} !== {expw(l1, 32), expw(r1, 32)})
      begin failures++; $display("FAIL ovf_held got=%h exp=%h", {o_left, o_right}, {expw(l1, 32), expw(r1, 32)}); end
    checks++; if (o_valid !== 1'b1 || o_overflow !== 1'b1)
      begin failures++; $display("FAIL ovf_flag got valid=%b ovf=%b exp valid=1 ovf=1", o_valid, o_overflow); end
    ready = 1'b1; tick(1); ready = 1'b0; tick(2);
    checks++; if (got.size() != 1 || got[0] !== {expw(l1, 32), expw(r1, 32)})
      begin failures++; $display("FAIL ovf_accept got=%0d pairs exp=1 of P1", got.size()); end
    checks++; if (o_valid !== 1'b0 || o_overflow !== 1'b1)
      begin failures++; $display("FAIL ovf_after_accept got valid=%b ovf=%b exp valid=0 ovf=1", o_valid, o_overflow); end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; tick(1);
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", o_overflow); end
  endtask

  task automatic test_word_length();
    logic [63:0] exp_q[$];
    logic [63:0] l, r;
    int n;
    ready = 1'b1;
    got.delete();
    add_frame(64'hAB_CDEF, 64'hAB_CDEF, 24);
    exp_q.push_back({32'hABCD_EF00, 32'hABCD_EF00});
    l = rnd(40); r = rnd(40);
    add_frame(l, r, 40);
    exp_q.push_back({expw(l, 40), expw(r, 40)});
    for (int f = 0; f < 2; f++) begin
      n = int'($urandom_range(8, 48));
      l = rnd(n); r = rnd(n);
      add_frame(l, r, n);
      exp_q.push_back({expw(l, n), expw(r, n)});
    end
    play_all(2);
    tick(8);
    checks++; if (got.size() != exp_q.size())
      begin failures++; $display("FAIL wlen_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL wlen_pair%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_disable_mid_word();
    logic [63:0] l, r;
    ready = 1'b0;
    got.delete();
    l = rnd(32); r = rnd(32);
    add_frame(l, r, 32);
    play_all(3);
    tick(6);
    add_frame(rnd(32), rnd(32), 32);
    add_frame(rnd(32), rnd(32), 32);
    play(0, 10, 3);
    enable = 1'b0;
    tick(2);
    play(10, chq.size(), 3);
    chq.delete(); sdq.delete();
    tick(6);
    checks++; if (o_valid !== 1'b1 || {o_left, o_right} !== {expw(l, 32), expw(r, 32)})
      begin failures++; $display("FAIL dis_held got valid=%b pair=%h exp valid=1 pair=%h", o_valid, {o_left, o_right}, {expw(l, 32), expw(r, 32)}); end
    checks++; if (o_overflow !== 1'b0 || got.size() != 0)
      begin failures++; $display("FAIL dis_nopair got ovf=%b pairs=%0d exp ovf=0 pairs=0", o_overflow, got.size()); end
    ready = 1'b1; tick(1); ready = 1'b0; tick(2);
    checks++; if (got.size() != 1 || got[0] !== {expw(l, 32), expw(r, 32)})
      begin failures++; $display("FAIL dis_deliver got=%0d pairs exp=1 held pair", got.size()); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL dis_valid_clear got=%b exp=0", o_valid); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_mid_frame_enable();
    test_overflow();
    test_word_length();
    test_disable_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
